bcd_serial_addsub: RTL and testbench

- Parametrised N-digit packed-BCD adder/subtractor, digit-serial: one BCD digit per clock, least significant digit first.
- Handles wide decimal operands with a single digit-adder cell, trading latency for area.
- Subtraction uses nines-complement plus carry-in; a negative result gets a second correction pass, so the output is always sign + magnitude.
- Used by the arithmetic datapath wherever multi-digit decimal results are needed under a start/done handshake.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_serial_addsub_if.sv | 31 +++
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_serial_addsub.sv | 165 ++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
// Holds the BCD digit constants, the controller state encoding and the
// nines-complement helper used by both the operand loader and the
// negative-result correction pass.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/done handshake bundle for bcd_serial_addsub.
// master (requester): drives start, sub, a, b; receives ready, done, s,
//   cout, neg (and err when BCD_INPUT_CHECK_EN is defined).
// slave (adder): the mirror image.
// Optional macro: BCD_INPUT_CHECK_EN adds the err signal.
interface bcd_serial_addsub_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   s;
  logic                  cout;
  logic                  neg;
`ifdef BCD_INPUT_CHECK_EN
  logic                  err;

  modport master (output start, sub, a, b,
                  input  ready, done, s, cout, neg, err);
  modport slave  (input  start, sub, a, b,
                  output ready, done, s, cout, neg, err);
`else
  modport master (output start, sub, a, b,
                  input  ready, done, s, cout, neg);
  modport slave  (input  start, sub, a, b,
                  output ready, done, s, cout, neg);
`endif
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single BCD digit adder cell.
// Ports: a, b - BCD digits; cin - carry in; s - corrected BCD digit;
//        cout - decimal carry out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] z;

  // A 5-bit sum above 9 covers both the decimal overflow and the binary
  // carry case, so one compare selects the +6 correction.
  always_comb begin
    z    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (z > 5'd9);
    s    = cout ? (z[3:0] + BCD_CORR) : z[3:0];
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit packed-BCD adder/subtractor, LSD first, one shared
// digit cell. Subtraction adds the nines complement of B plus one; a
// negative result gets a tens-complement pass so s is always a magnitude.
// Ports: clk, rst (async, active high); bus (slave modport): start, sub,
//   a, b in; ready, done, s, cout, neg (and err) out.
// Optional macro: BCD_INPUT_CHECK_EN - rejects operands with nibbles >9
//   and reports err instead of computing.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_addsub_if.slave   bus
);

  localparam int unsigned W  = DIGIT_W * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t          state, state_next;
  logic [IW-1:0]   idx;
  logic            c;
  logic            sub_r;
  logic [W-1:0]    ra, rb, r;
  logic [W-1:0]    s_q;
  logic            cout_q, neg_q;

  logic [3:0]      a_d, b_d, r_d;
  logic [3:0]      x, y, sum;
  logic            k;
  logic [W-1:0]    r_upd;
  logic [W-1:0]    b_in;
  logic            accept;
  logic            bad;
  logic            last;

  assign bus.ready = (state == IDLE) || (state == DONE);
  assign bus.done  = (state == DONE);
  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign bus.neg   = neg_q;

  assign accept = bus.start && bus.ready;
  assign last   = (idx == LAST);

  always_comb begin
    a_d   = '0;
    b_d   = '0;
    r_d   = '0;
    r_upd = r;
    b_in  = '0;
    bad   = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      b_in[j*DIGIT_W +: DIGIT_W] = bus.sub ? nines(bus.b[j*DIGIT_W +: DIGIT_W])
                                           : bus.b[j*DIGIT_W +: DIGIT_W];
`ifdef BCD_INPUT_CHECK_EN
      if ((bus.a[j*DIGIT_W +: DIGIT_W] > BCD_MAX) ||
          (bus.b[j*DIGIT_W +: DIGIT_W] > BCD_MAX))
        bad = 1'b1;
`endif
      if (idx == IW'(j)) begin
        a_d = ra[j*DIGIT_W +: DIGIT_W];
        b_d = rb[j*DIGIT_W +: DIGIT_W];
        r_d = r[j*DIGIT_W +: DIGIT_W];
        r_upd[j*DIGIT_W +: DIGIT_W] = sum;
      end
    end
  end

  // The single cell is shared: ADD feeds operand digits, FIX feeds the
  // nines complement of the partial result with a zero addend.
  always_comb begin
    x = (state == FIX) ? nines(r_d) : a_d;
    y = (state == FIX) ? 4'd0 : b_d;
  end

  bcd_digit_add u_cell (
    .a    (x),
    .b    (y),
    .cin  (c),
    .s    (sum),
    .cout (k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept)             state_next = bad ? DONE : ADD;
        else if (state == DONE) state_next = IDLE;
      end
      ADD: if (last) state_next = (sub_r && !k) ? FIX : DONE;
      FIX: if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

`ifdef BCD_INPUT_CHECK_EN
  logic err_q;
  assign bus.err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= bad;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      c      <= 1'b0;
      sub_r  <= 1'b0;
      ra     <= '0;
      rb     <= '0;
      r      <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      ra    <= bus.a;
      rb    <= b_in;
      sub_r <= bus.sub;
      c     <= bus.sub;
      idx   <= '0;
      r     <= '0;
      if (bad) begin
        s_q    <= '0;
        cout_q <= 1'b0;
        neg_q  <= 1'b0;
      end
    end else if (state == ADD) begin
      r <= r_upd;
      if (!last) begin
        idx <= idx + 1'b1;
        c   <= k;
      end else if (sub_r && !k) begin
        idx <= '0;
        c   <= 1'b1;
      end else begin
        c      <= k;
        s_q    <= r_upd;
        cout_q <= sub_r ? 1'b0 : k;
        neg_q  <= 1'b0;
      end
    end else if (state == FIX) begin
      r <= r_upd;
      c <= k;
      if (!last) begin
        idx <= idx + 1'b1;
      end else begin
        s_q    <= r_upd;
        cout_q <= 1'b0;
        neg_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub (DIGITS=4): the driver pushes the
// expected result of every accepted request, the monitor pops on done.
module tb_bcd_serial_addsub;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         neg;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  bcd_serial_addsub_if #(.DIGITS(D)) ifc ();

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    exp_t e;
    longint ia = to_int(av);
    longint ib = to_int(bv);
    longint lim = 1;
    logic inval = 1'b0;
    for (int i = 0; i < D; i++) lim = lim * 10;
    for (int i = 0; i < D; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) inval = 1'b1;
    e.err = 1'b0;
    e.t0  = 0;
    if (!sv) begin
      e.s = to_bcd((ia + ib) % lim); e.cout = (ia + ib) >= lim; e.neg = 1'b0;
      e.lat = D + 1;
    end else if (ia >= ib) begin
      e.s = to_bcd(ia - ib); e.cout = 1'b0; e.neg = 1'b0; e.lat = D + 1;
    end else begin
      e.s = to_bcd(ib - ia); e.cout = 1'b0; e.neg = 1'b1; e.lat = 2 * D + 1;
    end
`ifdef BCD_INPUT_CHECK_EN
    if (inval) begin
      e.s = '0; e.cout = 1'b0; e.neg = 1'b0; e.err = 1'b1; e.lat = 1;
    end
`else
    if (inval) e.lat = e.lat;
`endif
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && ifc.done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("s", 64'(ifc.s), 64'(e.s));
        chk("cout", 64'(ifc.cout), 64'(e.cout));
        chk("neg", 64'(ifc.neg), 64'(e.neg));
`ifdef BCD_INPUT_CHECK_EN
        chk("err", 64'(ifc.err), 64'(e.err));
`endif
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int n = 0;
    exp_t e;
    while (!ifc.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.ready) begin
      total++; bad++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    ifc.a = av; ifc.b = bv; ifc.sub = sv; ifc.start = 1'b1;
    e = model(av, bv, sv);
    e.t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !ifc.ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout actual=%0d required=0 pending", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.sub = 1'b0; ifc.a = '0; ifc.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ifc.ready), 64'd1);
    chk("rst_done", 64'(ifc.done), 64'd0);
    chk("rst_s", 64'(ifc.s), 64'd0);
    chk("rst_cout", 64'(ifc.cout), 64'd0);
    chk("rst_neg", 64'(ifc.neg), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h5678, 1'b0); wait_idle();
    issue(16'h9999, 16'h0001, 1'b0); wait_idle();
    issue(16'h0500, 16'h0123, 1'b1); wait_idle();
    issue(16'h0123, 16'h0500, 1'b1); wait_idle();
    issue(16'h4321, 16'h4321, 1'b1); wait_idle();
    issue(16'h0000, 16'h9999, 1'b1); wait_idle();

    // Busy start ignored, then a start in the done cycle is taken.
    issue(16'h1111, 16'h2222, 1'b0);
    ifc.a = 16'h5555; ifc.b = 16'h5555; ifc.sub = 1'b0; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    begin
      int n = 0;
      while (!ifc.done && n < 50) begin @(negedge clk); n++; end
      chk("done_seen", 64'(ifc.done), 64'd1);
    end
    issue(16'h0001, 16'h0002, 1'b0);
    wait_idle();

    // Reset in the middle of a subtraction.
    issue(16'h9999, 16'h0001, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("abort_ready", 64'(ifc.ready), 64'd1);
    chk("abort_done", 64'(ifc.done), 64'd0);
    chk("abort_s", 64'(ifc.s), 64'd0);
    chk("abort_neg", 64'(ifc.neg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0042, 16'h0058, 1'b0); wait_idle();

`ifdef BCD_INPUT_CHECK_EN
    issue(16'h12A4, 16'h0001, 1'b0); wait_idle();
    issue(16'h0007, 16'h0008, 1'b0); wait_idle();
`endif

    // Random operands, occasionally back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] av, bv;
      for (int j = 0; j < int'(D); j++) begin
        av[4*j +: 4] = 4'($urandom_range(9));
        bv[4*j +: 4] = 4'($urandom_range(9));
      end
      issue(av, bv, 1'($urandom_range(1)));
      if ($urandom_range(3) != 0) wait_idle();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
